// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and lane helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {IDLE, WRITE} stateT;

    function automatic logic [7:0] laneMask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        base = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
        return base << off;
    endfunction

    function automatic logic isAligned(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] low;
        low = size == SZ_B ? 3'd0 : size == SZ_H ? 3'd1 : size == SZ_W ? 3'd3 : 3'd7;
        return (off & low) == 3'd0;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational lane extract/extend for loads and lane merge for stores
//   size, isSigned, off : request size, sign-extend flag, byte offset in word
//   ramData             : current RAM word
//   wData               : right-aligned store data
//   loadData            : extended load result
//   mergeData           : ramData with the selected lanes replaced by wData
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [2:0]  off,
    input  logic [63:0] ramData,
    input  logic [63:0] wData,
    output logic [63:0] loadData,
    output logic [63:0] mergeData
);
    logic [63:0] shifted;
    logic [63:0] bitMask;
    logic [7:0]  lanes;
    always_comb begin
        shifted = ramData >> {off, 3'b000};
        loadData = size == SZ_B ? {{56{isSigned & shifted[7]}}, shifted[7:0]} :
                   size == SZ_H ? {{48{isSigned & shifted[15]}}, shifted[15:0]} :
                   size == SZ_W ? {{32{isSigned & shifted[31]}}, shifted[31:0]} : shifted;
        lanes = laneMask(size, off);
        bitMask = '0;
        for (int i = 0; i < 8; i++) bitMask[8*i +: 8] = {8{lanes[i]}};
        mergeData = (ramData & ~bitMask) | ((wData << {off, 3'b000}) & bitMask);
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: byte-addressed load/store unit in front of a 64-bit word RAM
//   req_*   : request handshake (valid/ready), store flag, size, sign, byte address, store data
//   resp_*  : one-cycle response pulse with extended load data and misalignment error
//   ram_*   : word address, write data/enable to the RAM, combinational read data back
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [ADR_W+2:0] req_adr,
    input  logic [63:0]      req_wdata,
    output logic             resp_valid,
    output logic [63:0]      resp_rdata,
    output logic             resp_err,
    output logic [ADR_W-1:0] ram_adr,
    output logic [63:0]      ram_writeData,
    output logic             ram_writeEn,
    input  logic [63:0]      ram_readData
);
    stateT            state, nextState;
    logic             fire, aligned, subStore;
    logic [63:0]      loadData, mergeData, wData;
    logic [ADR_W-1:0] wAdr;

    lsu_align uAlign (
        .size     (req_size),
        .isSigned (req_signed),
        .off      (req_adr[2:0]),
        .ramData  (ram_readData),
        .wData    (req_wdata),
        .loadData (loadData),
        .mergeData(mergeData)
    );

    always_comb begin
        req_ready = state == IDLE;
        fire = req_valid && state == IDLE;
        aligned = isAligned(req_size, req_adr[2:0]);
        subStore = fire && aligned && req_write && req_size != SZ_D;
        ram_adr = state == WRITE ? wAdr : req_adr[ADR_W+2:3];
        ram_writeData = state == WRITE ? wData : req_wdata;
        // WRITE term is decoded from state so an async reset drops it at once
        ram_writeEn = state == WRITE || (fire && aligned && req_write && req_size == SZ_D);
        nextState = subStore ? WRITE : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            wAdr <= '0;
            wData <= '0;
        end else begin
            resp_valid <= state == WRITE || (fire && !subStore);
            resp_err <= fire && !aligned;
            resp_rdata <= fire && aligned && !req_write ? loadData : '0;
            if (subStore) begin
                wAdr <= req_adr[ADR_W+2:3];
                wData <= mergeData;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench with a byte-level memory model and a word RAM
module tb_mem_lsu;
    localparam int ADR_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [1:0]       req_size = '0;
    logic             req_signed = 1'b0;
    logic [ADR_W+2:0] req_adr = '0;
    logic [63:0]      req_wdata = '0;
    logic             resp_valid;
    logic [63:0]      resp_rdata;
    logic             resp_err;
    logic [ADR_W-1:0] ram_adr;
    logic [63:0]      ram_writeData;
    logic             ram_writeEn;
    logic [63:0]      ram_readData;

    logic [63:0] mem [0:(1<<ADR_W)-1];
    logic [7:0]  refB [0:127];
    int nCmp = 0;
    int nFail = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [18:0] adr;
        logic [63:0] wd;
        logic [63:0] expR;
        logic        expE;
        int          expLat;
    } vecT;
    vecT tbl [8];

    mem_lsu #(.ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_adr(req_adr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_adr(ram_adr), .ram_writeData(ram_writeData), .ram_writeEn(ram_writeEn),
        .ram_readData(ram_readData)
    );

    always #5 clk = ~clk;
    assign ram_readData = mem[ram_adr];
    always @(posedge clk) if (ram_writeEn) mem[ram_adr] <= ram_writeData;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] modelLoad(input logic [1:0] sz, input logic sg, input int adr);
        int nb;
        logic [63:0] v;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(refB[adr+i]) << (8*i));
        if (sg && nb < 8 && v[8*nb-1]) v = v | ({64{1'b1}} << (8*nb));
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] sz, input int adr, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) refB[adr+i] = 8'(wd >> (8*i));
    endtask

    task automatic runOp(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [18:0] adr, input logic [63:0] wd,
                         input logic [63:0] expR, input logic expE, input int expLat);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_adr = adr; req_wdata = wd;
        #1;
        chk({nm, ".ready"}, 64'(req_ready), 64'd1);
        chk({nm, ".weFire"}, 64'(ram_writeEn), 64'(w && sz == 2'd3 && !expE));
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({nm, ".weAfter"}, 64'(ram_writeEn), 64'(expLat == 2));
                chk({nm, ".readyAfter"}, 64'(req_ready), 64'(expLat != 2));
            end
        end while (!resp_valid && k < 5);
        chk({nm, ".lat"}, 64'(k), 64'(expLat));
        chk({nm, ".rdata"}, resp_rdata, expR);
        chk({nm, ".err"}, 64'(resp_err), 64'(expE));
        if (w && !expE) modelStore(sz, int'(adr), wd);
    endtask

    initial begin
        logic        w, sg, al;
        logic [1:0]  sz;
        int          adr, nb;
        logic [63:0] wd, keep;

        for (int i = 0; i < (1 << ADR_W); i++) mem[i] = '0;
        for (int i = 0; i < 128; i++) refB[i] = '0;

        tbl[0] = '{1'b1, 2'd3, 1'b0, 19'h40, 64'h1122334455667788, 64'h0, 1'b0, 1};
        tbl[1] = '{1'b0, 2'd3, 1'b0, 19'h40, 64'h0, 64'h1122334455667788, 1'b0, 1};
        tbl[2] = '{1'b1, 2'd0, 1'b0, 19'h43, 64'hAB, 64'h0, 1'b0, 2};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 19'h43, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 1};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 19'h43, 64'h0, 64'h00000000000000AB, 1'b0, 1};
        tbl[5] = '{1'b0, 2'd1, 1'b1, 19'h42, 64'h0, 64'hFFFFFFFFFFFFAB66, 1'b0, 1};
        tbl[6] = '{1'b1, 2'd2, 1'b0, 19'h42, 64'hDEADBEEF, 64'h0, 1'b1, 1};
        tbl[7] = '{1'b0, 2'd3, 1'b0, 19'h40, 64'h0, 64'h11223344AB667788, 1'b0, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.valid", 64'(resp_valid), 64'd0);
        chk("rst.rdata", resp_rdata, 64'd0);
        chk("rst.err", 64'(resp_err), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.we", 64'(ram_writeEn), 64'd0);

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("t%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].adr, tbl[i].wd,
                  tbl[i].expR, tbl[i].expE, tbl[i].expLat);
            if (i == 2 || i == 6) chk($sformatf("t%0d.mem8", i), mem[8], 64'h11223344AB667788);
        end

        // back-to-back loads, one per cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_adr = 19'h40;
        @(posedge clk);
        #1 req_size = 2'd0; req_adr = 19'h41;
        @(negedge clk);
        chk("b2b.valid0", 64'(resp_valid), 64'd1);
        chk("b2b.rdata0", resp_rdata, modelLoad(2'd3, 1'b0, 64));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b.valid1", 64'(resp_valid), 64'd1);
        chk("b2b.rdata1", resp_rdata, 64'h77);
        @(negedge clk);
        chk("b2b.idle", 64'(resp_valid), 64'd0);

        // reset in the middle of a sub-word store
        keep = modelLoad(2'd3, 1'b0, 72);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_adr = 19'h48; req_wdata = 64'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rw.weWrite", 64'(ram_writeEn), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rw.weDrop", 64'(ram_writeEn), 64'd0);
        chk("rw.ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rw.mem9", mem[9], keep);
        repeat (2) begin
            @(negedge clk);
            chk("rw.noResp", 64'(resp_valid), 64'd0);
        end

        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            nb = 1 << sz;
            adr = int'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) adr = adr & ~(nb - 1);
            wd = {$urandom, $urandom};
            al = (adr % nb) == 0;
            runOp($sformatf("r%0d", n), w, sz, sg, 19'(adr), wd,
                  (!w && al) ? modelLoad(sz, sg, adr) : 64'd0, !al, (w && al && sz != 2'd3) ? 2 : 1);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("final.mem%0d", i), mem[i], modelLoad(2'd3, 1'b0, 8*i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the 64-bit data RAM (16-bit word address, combinational read, write on posedge clk).
- Accepts byte-addressed load/store requests of 8/16/32/64 bits from the execute stage and handles alignment checking.
- Performs read-modify-write for sub-word stores and extracts/sign-extends load data.
- Returns one response per request.

Parameters:
ADR_W, 16, RAM word-address width; byte address is ADR_W+3 bits. Data width is fixed at 64.

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept; request fires when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_signed  in  1  loads only: sign-extend (1) or zero-extend (0)
req_adr  in  ADR_W+3  byte address; [ADR_W+2:3] = word, [2:0] = byte offset
req_wdata  in  64  store data, right-aligned (valid bits in LSBs)
resp_valid  out  1  one-cycle pulse; consumer always accepts (no backpressure)
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  misaligned request, valid with resp_valid
ram_adr  out  ADR_W  to RAM address
ram_writeData  out  64  to RAM write data
ram_writeEn  out  1  to RAM write enable
ram_readData  in  64  from RAM, combinational on ram_adr

Behaviour:
- Reset: state IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0. Combinational outputs in IDLE with no fire: req_ready = 1, ram_writeEn = 0.
- Layout: little-endian; byte k of a word is bits [8k+7:8k].
- Alignment: offset must be a multiple of (1 << req_size), otherwise the request is misaligned.
- States: IDLE, WRITE.
- IDLE behaviour:
  - req_ready = 1.
  - ram_adr = req_adr word field.
  - ram_writeEn = fire && req_write && size==3 && aligned.
  - ram_writeData = req_wdata.
- Fire, aligned load: at the edge, latch resp_rdata = lane extracted from ram_readData, then zero- or sign-extended to 64; resp_valid = 1 next cycle. Latency 1; back-to-back loads at 1 per cycle.
- Fire, aligned dword store: RAM written at the same edge; resp_valid next cycle, resp_rdata = 0.
- Fire, aligned sub-word store (size 0–2):
  - At the edge, latch the merged word: ram_readData with the selected lanes replaced by the low bytes of req_wdata.
  - Latch the word address; go to WRITE.
  - No response yet.
- WRITE (exactly 1 cycle):
  - req_ready = 0.
  - ram_adr = latched address; ram_writeData = merged word; ram_writeEn = 1.
  - At the edge: return to IDLE, resp_valid = 1 next cycle.
  - Sub-word store latency 2; a following request is accepted no earlier than the cycle after WRITE, which preserves RAW ordering.
- Fire, misaligned (any type): no RAM write. Next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0.
- resp_valid deasserts after one cycle unless another response is produced.
- req_valid low: no state change besides clearing resp_valid.
- Reset asserted during WRITE: ram_writeEn drops immediately (decoded from state); memory is not written; no response.

Decomposition:
- Package lsu_pkg:
  - size encodings (SZ_B/H/W/D)
  - state enum (IDLE, WRITE)
  - function for the byte-lane mask from size and offset
  - function for the alignment check
- Sub-module lsu_align (combinational):
  - load path: extract + extend
  - store path: lane merge
- mem_lsu holds the FSM and registers.

Test Plan:
- Reset then idle, req_valid = 0 → resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1, ram_writeEn = 0.
- Dword store 0x1122334455667788 to byte adr 0x40, then dword load at 0x40 → RAM word 8 written at the fire edge; load resp_rdata = 0x1122334455667788 one cycle after fire.
- Byte store 0xAB to adr 0x43 over the previous word → ram_writeEn high only in the WRITE cycle; req_ready low that cycle; word becomes 0x11223344AB667788; resp_valid 2 cycles after fire.
- Signed byte load adr 0x43 → 0xFFFFFFFFFFFFFFAB; unsigned → 0xAB; signed half load adr 0x42 → 0xFFFFFFFFFFFFAB66.
- Word store at adr 0x42 (misaligned) → no ram_writeEn; next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0; memory unchanged.
- Half store, rst pulsed during WRITE → ram_writeEn deasserts immediately; word unchanged; no resp_valid; req_ready = 1 after reset.
